// File: rtl/ch_seq.sv
// Channel scan sequencer: on a qualified strobe, walks the set bits of a latched
// channel mask in ascending order with a valid/ready handshake per channel.
module ch_seq #(
   parameter int NCH   = 8,
   parameter int SEL_W = 3,
   parameter int OVR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic             en,
   input  logic [NCH-1:0]   ch_mask,
   input  logic             ready,
   input  logic             clr_ovr,
   output logic             req_data,
   output logic             valid,
   output logic [SEL_W-1:0] sel,
   output logic             first,
   output logic             last,
   output logic [OVR_W-1:0] ovr_cnt
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state_reg;
   logic [NCH-1:0]   mask_reg;
   logic [SEL_W-1:0] sel_reg;
   logic             valid_reg;
   logic             req_reg;
   logic             first_reg;
   logic             last_reg;
   logic [OVR_W-1:0] ovr_reg;

   logic             trigger;
   logic             start_ok;
   logic             handshake;
   logic             drop;
   logic [SEL_W-1:0] start_sel;
   logic             start_last;
   logic [SEL_W-1:0] next_sel;
   logic             next_last;

   // Lowest set bit of v at or above index start (0 if none).
   function automatic logic [SEL_W-1:0] lowest_from(input logic [NCH-1:0] v, input int start);
      lowest_from = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i] && i >= start) lowest_from = SEL_W'(i);
      end
   endfunction

   function automatic logic any_above(input logic [NCH-1:0] v, input logic [SEL_W-1:0] idx);
      any_above = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (v[i] && i > int'(idx)) any_above = 1'b1;
      end
   endfunction

   always_comb begin
      trigger    = strobe & en;
      start_ok   = trigger & (|ch_mask);
      handshake  = valid_reg & ready;
      start_sel  = lowest_from(ch_mask, 0);
      start_last = !any_above(ch_mask, start_sel);
      next_sel   = lowest_from(mask_reg, int'(sel_reg) + 1);
      next_last  = !any_above(mask_reg, next_sel);
      // A trigger coinciding with the final handshake chains a new scan instead of dropping.
      drop       = (state_reg == SCAN) & trigger & !(handshake & last_reg);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         mask_reg  <= '0;
         sel_reg   <= '0;
         valid_reg <= 1'b0;
         req_reg   <= 1'b0;
         first_reg <= 1'b0;
         last_reg  <= 1'b0;
         ovr_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_ok) begin
                  state_reg <= SCAN;
                  mask_reg  <= ch_mask;
                  sel_reg   <= start_sel;
                  valid_reg <= 1'b1;
                  req_reg   <= 1'b1;
                  first_reg <= 1'b1;
                  last_reg  <= start_last;
               end
            end
            SCAN: begin
               if (handshake) begin
                  if (last_reg) begin
                     if (start_ok) begin
                        mask_reg  <= ch_mask;
                        sel_reg   <= start_sel;
                        first_reg <= 1'b1;
                        last_reg  <= start_last;
                     end else begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b0;
                        first_reg <= 1'b0;
                        last_reg  <= 1'b0;
                     end
                  end else begin
                     sel_reg   <= next_sel;
                     first_reg <= 1'b0;
                     last_reg  <= next_last;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (clr_ovr)
            ovr_reg <= '0;
         else if (drop && ovr_reg != {OVR_W{1'b1}})
            ovr_reg <= ovr_reg + 1'b1;
      end
   end

   assign req_data = req_reg;
   assign valid    = valid_reg;
   assign sel      = sel_reg;
   assign first    = first_reg;
   assign last     = last_reg;
   assign ovr_cnt  = ovr_reg;

endmodule
